// File: rtl/skew_pkg.sv
// Shared defaults and sizing helper for the skewed register bank.
package skew_pkg;

   localparam int SKEW_WIDTH_DEF = 8;
   localparam int SKEW_LANES_DEF = 4;

   // Lane k holds k+1 stages, so the bank stores a triangular number of stages.
   function automatic int skew_stage_count(input int lanes);
      return (lanes * (lanes + 1)) / 2;
   endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew bank: a DEPTH-stage {valid, data} shift chain with bubble zeroing.
// Optional synchronous flush port clr exists only when SKEW_CLR_EN is defined.
module skew_lane
   import skew_pkg::*;
#(
   parameter int WIDTH = SKEW_WIDTH_DEF,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SKEW_CLR_EN
   input  logic             clr,
`endif
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic [WIDTH-1:0] q,
   output logic             q_valid
);

   logic [DEPTH-1:0][WIDTH-1:0] data_q;
   logic [DEPTH-1:0][WIDTH-1:0] data_d;
   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0]            valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (en) begin
         // A bubble enters as all-zero data so downstream accumulators see nothing.
         valid_d[0] = d_valid;
         data_d[0]  = d_valid ? d : '0;
         for (int j = 1; j < DEPTH; j++) begin
            valid_d[j] = valid_q[j-1];
            data_d[j]  = data_q[j-1];
         end
      end
`ifdef SKEW_CLR_EN
      if (clr) begin
         valid_d = '0;
         data_d  = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         valid_q <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q       = data_q[DEPTH-1];
   assign q_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/skew_register_bank.sv
// Multi-lane skew bank: lane k delays its operand by k+1 enabled cycles to form a diagonal wavefront.
// Define SKEW_CLR_EN to add the synchronous flush input clr.
module skew_register_bank
   import skew_pkg::*;
#(
   parameter int WIDTH = SKEW_WIDTH_DEF,
   parameter int LANES = SKEW_LANES_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
`ifdef SKEW_CLR_EN
   input  logic                   clr,
`endif
   input  logic                   en,
   input  logic [LANES*WIDTH-1:0] in,
   input  logic [LANES-1:0]       in_valid,
   output logic [LANES*WIDTH-1:0] out,
   output logic [LANES-1:0]       out_valid
);

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      skew_lane #(
         .WIDTH (WIDTH),
         .DEPTH (k + 1)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
`ifdef SKEW_CLR_EN
         .clr     (clr),
`endif
         .en      (en),
         .d       (in[k*WIDTH +: WIDTH]),
         .d_valid (in_valid[k]),
         .q       (out[k*WIDTH +: WIDTH]),
         .q_valid (out_valid[k])
      );
   end

endmodule

// File: tb/tb_skew_register_bank.sv
// Scoreboard bench for skew_register_bank (WIDTH=8, LANES=4), plus directed wavefront checks.
module tb_skew_register_bank;
   import skew_pkg::*;

   localparam int W        = 8;
   localparam int L        = 4;
   localparam int SB_DEPTH = 4 * skew_stage_count(L);

   typedef struct {
      logic [W-1:0] data;
      int           due;
      int           epoch;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [L*W-1:0]   din;
   logic [L-1:0]     din_valid;
   logic [L*W-1:0]   dout;
   logic [L-1:0]     dout_valid;
`ifdef SKEW_CLR_EN
   logic             clr;
`endif

   int   checks   = 0;
   int   failures = 0;

   exp_t sb [L][SB_DEPTH];
   int   wr_ptr [L];
   int   rd_ptr [L];
   int   edge_cnt;
   int   epoch;
   bit   last_en;

   skew_register_bank #(.WIDTH(W), .LANES(L)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef SKEW_CLR_EN
      .clr       (clr),
`endif
      .en        (en),
      .in        (din),
      .in_valid  (din_valid),
      .out       (dout),
      .out_valid (dout_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string name, input logic [L*W-1:0] eo, input logic [L-1:0] ev);
      chk({name, "_data"}, 64'(dout), 64'(eo));
      chk({name, "_valid"}, 64'(dout_valid), 64'(ev));
   endtask

   task automatic step(input logic e, input logic [L*W-1:0] d, input logic [L-1:0] v);
      en        = e;
      din       = d;
      din_valid = v;
      @(posedge clk);
      #2;
   endtask

   // Producer: records what each enabled edge captured and when it must emerge.
   initial begin
      edge_cnt = 0;
      epoch    = 0;
      last_en  = 1'b0;
      for (int k = 0; k < L; k++) wr_ptr[k] = 0;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            epoch++;
            last_en = 1'b0;
         end
`ifdef SKEW_CLR_EN
         else if (clr) begin
            epoch++;
            last_en = 1'b1;
         end
`endif
         else begin
            last_en = en;
            if (en) begin
               for (int k = 0; k < L; k++) begin
                  if (din_valid[k]) begin
                     sb[k][wr_ptr[k] % SB_DEPTH] = '{din[k*W +: W], edge_cnt + 1 + k, epoch};
                     wr_ptr[k]++;
                  end
               end
               edge_cnt++;
            end
         end
      end
   end

   // Monitor: pops an expectation whenever a lane shows valid after an enabled edge.
   initial begin
      logic [W-1:0] d;
      logic         v;
      logic [W:0]   prev [L];
      int           prev_epoch;
      prev_epoch = -1;
      for (int k = 0; k < L; k++) begin
         rd_ptr[k] = 0;
         prev[k]   = '0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < L; k++) begin
            d = dout[k*W +: W];
            v = dout_valid[k];
            if (!v) chk("bubble_zero", 64'(d), 64'(0));
            if (reset && last_en && v) begin
               while (rd_ptr[k] < wr_ptr[k] && sb[k][rd_ptr[k] % SB_DEPTH].epoch != epoch)
                  rd_ptr[k]++;
               if (rd_ptr[k] < wr_ptr[k]) begin
                  chk("sb_data", 64'(d), 64'(sb[k][rd_ptr[k] % SB_DEPTH].data));
                  chk("sb_latency", 64'(edge_cnt), 64'(sb[k][rd_ptr[k] % SB_DEPTH].due));
                  rd_ptr[k]++;
               end else begin
                  chk("sb_unexpected_valid", 64'(v), 64'(0));
               end
            end
            if (reset && !last_en && epoch == prev_epoch)
               chk("stall_hold", 64'({v, d}), 64'(prev[k]));
            prev[k] = {v, d};
         end
         prev_epoch = reset ? epoch : -1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pend;
      reset     = 1'b1;
      en        = 1'b0;
      din       = '0;
      din_valid = '0;
`ifdef SKEW_CLR_EN
      clr       = 1'b0;
`endif
      // Asynchronous reset before any clock edge
      #3 reset = 1'b0;
      #1 expect_out("reset_async", 32'h0, 4'h0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 32'hDEAD_BEEF, 4'hF);
         expect_out("reset_hold_en0", 32'h0, 4'h0);
      end

      // Wavefront
      step(1'b1, 32'h4433_2211, 4'hF); expect_out("wave_e1", 32'h0000_0011, 4'b0001);
      step(1'b1, 32'h0, 4'h0);         expect_out("wave_e2", 32'h0000_2200, 4'b0010);
      step(1'b1, 32'h0, 4'h0);         expect_out("wave_e3", 32'h0033_0000, 4'b0100);
      step(1'b1, 32'h0, 4'h0);         expect_out("wave_e4", 32'h4400_0000, 4'b1000);
      step(1'b1, 32'h0, 4'h0);         expect_out("wave_e5", 32'h0, 4'h0);

      // Stall after edge 2; inputs during the stall must be ignored
      step(1'b1, 32'h4433_2211, 4'hF); expect_out("stall_e1", 32'h0000_0011, 4'b0001);
      step(1'b1, 32'h0, 4'h0);         expect_out("stall_e2", 32'h0000_2200, 4'b0010);
      step(1'b0, 32'hAAAA_AAAA, 4'hF); expect_out("stall_e3", 32'h0000_2200, 4'b0010);
      step(1'b0, 32'hBBBB_BBBB, 4'hF); expect_out("stall_e4", 32'h0000_2200, 4'b0010);
      step(1'b1, 32'h0, 4'h0);         expect_out("stall_e5", 32'h0033_0000, 4'b0100);
      step(1'b1, 32'h0, 4'h0);         expect_out("stall_e6", 32'h4400_0000, 4'b1000);
      step(1'b1, 32'h0, 4'h0);         expect_out("stall_e7", 32'h0, 4'h0);

      // Bubble zeroing on lanes 1 and 3
      step(1'b1, 32'hFFFF_FFFF, 4'b0101); expect_out("bubble_e1", 32'h0000_00FF, 4'b0001);
      step(1'b1, 32'h0, 4'h0);            expect_out("bubble_e2", 32'h0, 4'h0);
      step(1'b1, 32'h0, 4'h0);            expect_out("bubble_e3", 32'h00FF_0000, 4'b0100);
      step(1'b1, 32'h0, 4'h0);            expect_out("bubble_e4", 32'h0, 4'h0);

      // Reset mid-stream
      for (int i = 1; i <= 5; i++) step(1'b1, {4{8'(i)}}, 4'hF);
      expect_out("midrst_pre", 32'h0203_0405, 4'hF);
      reset = 1'b0;
      #1 expect_out("midrst_async", 32'h0, 4'h0);
      step(1'b1, 32'h0606_0606, 4'hF);
      step(1'b1, 32'h0707_0707, 4'hF);
      expect_out("midrst_held", 32'h0, 4'h0);
      reset = 1'b1;
      step(1'b1, 32'h0808_0808, 4'hF); expect_out("midrst_e1", 32'h0000_0008, 4'b0001);
      step(1'b1, 32'h0, 4'h0);         expect_out("midrst_e2", 32'h0000_0800, 4'b0010);
      step(1'b1, 32'h0, 4'h0);         expect_out("midrst_e3", 32'h0008_0000, 4'b0100);
      step(1'b1, 32'h0, 4'h0);         expect_out("midrst_e4", 32'h0800_0000, 4'b1000);
      step(1'b1, 32'h0, 4'h0);         expect_out("midrst_e5", 32'h0, 4'h0);

      // en toggling every cycle: only even-indexed values are captured
      for (int i = 0; i < 8; i++) step((i % 2) == 0, {4{8'(8'h10 + i)}}, 4'hF);
      expect_out("toggle_end", 32'h1012_1416, 4'hF);
      for (int i = 0; i < L; i++) step(1'b1, 32'h0, 4'h0);
      expect_out("toggle_drained", 32'h0, 4'h0);

`ifdef SKEW_CLR_EN
      for (int i = 0; i < L; i++) step(1'b1, 32'h5555_5555, 4'hF);
      expect_out("flush_full", 32'h5555_5555, 4'hF);
      clr = 1'b1;
      step(1'b1, 32'h9999_9999, 4'hF);
      clr = 1'b0;
      expect_out("flush_edge", 32'h0, 4'h0);
      for (int i = 0; i < L; i++) begin
         step(1'b1, 32'h0, 4'h0);
         expect_out("flush_after", 32'h0, 4'h0);
      end
`endif

      step(1'b1, 32'h0, 4'h0);
      @(negedge clk); #1;
      for (int k = 0; k < L; k++) begin
         pend = 0;
         for (int p = rd_ptr[k]; p < wr_ptr[k]; p++)
            if (sb[k][p % SB_DEPTH].epoch == epoch) pend++;
         chk($sformatf("sb_drain_lane%0d", k), 64'(pend), 64'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
